// File: rtl/fv_xbar_arb_pkg.sv
// Shared definitions for the feature-vector crossbar: default bank/PE counts,
// the beat layout used by the bank controllers, and a width helper.
package fv_xbar_arb_pkg;

    localparam int NUM_BANKS_FV = 4;
    localparam int NUM_EDGE_PE  = 4;
    localparam int FV_DATA_W    = 64;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FV_TAG_W = clog2_min1(NUM_EDGE_PE);

    typedef struct packed {
        logic                 sos;
        logic                 eos;
        logic [FV_TAG_W-1:0]  tag;
        logic [FV_DATA_W-1:0] data;
    } fv_beat_t;

endpackage

// File: rtl/fv_xbar_arb_src_fifo.sv
// Per-source beat FIFO with count-based full/empty; the head is presented
// combinationally so the arbiter can inspect its tag before popping.
module fv_src_fifo
    import fv_xbar_arb_pkg::*;
#(
    parameter type beat_t = fv_beat_t,
    parameter int  DEPTH  = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  beat_t push_beat,
    input  logic  pop,
    output beat_t head,
    output logic  head_valid,
    output logic  full
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    beat_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;
    assign head       = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_beat;
    end

endmodule

// File: rtl/fv_xbar_arb.sv
// Bank-to-edge-PE feature-vector crossbar: per-source FIFOs, per-destination
// round-robin arbitration with sos..eos stream locking, registered outputs.
module fv_xbar_arb
    import fv_xbar_arb_pkg::*;
#(
    parameter int NUM_SRC    = NUM_BANKS_FV,
    parameter int NUM_DST    = NUM_EDGE_PE,
    parameter int DATA_W     = FV_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = clog2_min1(NUM_DST),
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC-1:0]        src_sos,
    input  logic [NUM_SRC-1:0]        src_eos,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_DST-1:0]        dst_valid,
    input  logic [NUM_DST-1:0]        dst_ready,
    output logic [NUM_DST-1:0]        dst_sos,
    output logic [NUM_DST-1:0]        dst_eos,
    output logic [NUM_DST*DATA_W-1:0] dst_data,
    output logic [CNT_W-1:0]          conflict_cnt,
    output logic                      err_bad_tag,
    output logic                      err_proto
);

    localparam int SRC_W = clog2_min1(NUM_SRC);

    typedef struct packed {
        logic              sos;
        logic              eos;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t              in_beat [NUM_SRC];
    beat_t              head    [NUM_SRC];
    logic [NUM_SRC-1:0] head_v;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] bad_tag;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] gnt_oh  [NUM_DST];
    logic [NUM_DST-1:0] conflict_hit;
    logic [NUM_DST-1:0] proto_hit;

    logic [CNT_W-1:0]   conflict_q;
    logic [CNT_W:0]     cnt_sum;
    logic               bad_tag_q;
    logic               proto_q;

    assign src_ready = ~fifo_full;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign in_beat[s] = {src_sos[s], src_eos[s],
                             src_tag[s*TAG_W +: TAG_W],
                             src_data[s*DATA_W +: DATA_W]};

        fv_src_fifo #(
            .beat_t (beat_t),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (src_valid[s]),
            .push_beat  (in_beat[s]),
            .pop        (pop[s]),
            .head       (head[s]),
            .head_valid (head_v[s]),
            .full       (fifo_full[s])
        );

        // Heads addressing a nonexistent PE are discarded without output.
        assign bad_tag[s] = head_v[s] && (int'(head[s].tag) >= NUM_DST);
    end

    always_comb begin
        pop = bad_tag;
        for (int d = 0; d < NUM_DST; d++) begin
            pop = pop | gnt_oh[d];
        end
    end

    for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
        logic [NUM_SRC-1:0] req;
        logic [NUM_SRC-1:0] elig;
        logic [NUM_SRC-1:0] gnt_vec;
        logic               lock_v;
        logic [SRC_W-1:0]   lock_src;
        logic [SRC_W-1:0]   rr_ptr;
        logic [SRC_W-1:0]   cand;
        logic [SRC_W-1:0]   gnt_idx;
        logic               gnt_found;
        logic               can_load;
        logic               out_v;
        logic               out_sos;
        logic               out_eos;
        logic [DATA_W-1:0]  out_data;

        assign can_load = !out_v || dst_ready[d];

        always_comb begin
            req = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                req[s] = head_v[s] && !bad_tag[s] && (head[s].tag == TAG_W'(d));
            end
        end

        // A locked destination only listens to the owner of the open stream.
        always_comb begin
            elig = req;
            if (lock_v) begin
                elig           = '0;
                elig[lock_src] = req[lock_src];
            end
        end

        always_comb begin
            gnt_found = 1'b0;
            gnt_idx   = '0;
            cand      = '0;
            gnt_vec   = '0;
            for (int i = 1; i <= NUM_SRC; i++) begin
                cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
                if (!gnt_found && elig[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
            if (!can_load) gnt_found = 1'b0;
            if (gnt_found) gnt_vec[gnt_idx] = 1'b1;
        end

        assign gnt_oh[d]       = gnt_vec;
        assign conflict_hit[d] = can_load && ($countones(elig) >= 2);
        assign proto_hit[d]    = gnt_found &&
                                 (( head[gnt_idx].sos &&  lock_v) ||
                                  (!head[gnt_idx].sos && !lock_v));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lock_v   <= 1'b0;
                lock_src <= '0;
                rr_ptr   <= SRC_W'(NUM_SRC - 1);
                out_v    <= 1'b0;
                out_sos  <= 1'b0;
                out_eos  <= 1'b0;
                out_data <= '0;
            end else begin
                if (can_load) out_v <= gnt_found;
                if (gnt_found) begin
                    out_sos  <= head[gnt_idx].sos;
                    out_eos  <= head[gnt_idx].eos;
                    out_data <= head[gnt_idx].data;
                    rr_ptr   <= gnt_idx;
                    if (head[gnt_idx].eos) begin
                        lock_v <= 1'b0;
                    end else if (head[gnt_idx].sos) begin
                        lock_v   <= 1'b1;
                        lock_src <= gnt_idx;
                    end
                end
            end
        end

        assign dst_valid[d]                = out_v;
        assign dst_sos[d]                  = out_sos;
        assign dst_eos[d]                  = out_eos;
        assign dst_data[d*DATA_W +: DATA_W] = out_data;
    end

    always_comb begin
        cnt_sum = {1'b0, conflict_q} + (CNT_W+1)'($countones(conflict_hit));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= '0;
            bad_tag_q  <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            conflict_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            bad_tag_q  <= bad_tag_q | (|bad_tag);
            proto_q    <= proto_q | (|proto_hit);
        end
    end

    assign conflict_cnt = conflict_q;
    assign err_bad_tag  = bad_tag_q;
    assign err_proto    = proto_q;

endmodule

// File: doc/fv_xbar_arb.md
Name: fv_xbar_arb

Overview:
- Parametrised successor to the bank-to-edge-PE feature-vector bus.
- Routes FV beats from NUM_SRC bank controllers to NUM_DST edge PEs by destination tag.
- The old bus silently overwrote colliding beats; this block replaces that with per-source buffering, per-destination round-robin arbitration, sos..eos stream locking, ready/valid backpressure on both sides, and conflict/error telemetry.
- Sits between the FV bank controllers and the edge PE array.

Parameters:
- NUM_SRC, 4, number of FV bank controllers (sources).
- NUM_DST, 4, number of edge PEs (destinations).
- DATA_W, 64, FV_data width per beat.
- FIFO_DEPTH, 2, entries per source FIFO; power of 2, >=2.
- TAG_W, $clog2(NUM_DST) (min 1), destination tag width.
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  beat valid per source.
- src_ready  out  NUM_SRC  source FIFO not full.
- src_tag  in  NUM_SRC*TAG_W  destination PE tag.
- src_sos  in  NUM_SRC  start of stream.
- src_eos  in  NUM_SRC  end of stream.
- src_data  in  NUM_SRC*DATA_W  FV data.
- dst_valid  out  NUM_DST  registered beat valid.
- dst_ready  in  NUM_DST  PE can accept.
- dst_sos  out  NUM_DST  registered sos.
- dst_eos  out  NUM_DST  registered eos.
- dst_data  out  NUM_DST*DATA_W  registered FV data.
- conflict_cnt  out  CNT_W  saturating arbitration-conflict count.
- err_bad_tag  out  1  sticky: tag >= NUM_DST seen.
- err_proto  out  1  sticky: sos while locked, or non-sos beat while unlocked.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - All outputs 0 except src_ready = all 1s.
  - FIFOs empty; locks cleared; rr_ptr[d] = NUM_SRC-1, so source 0 has first priority.
  - Reset mid-stream discards all buffered and registered beats.
- Source side:
  - Push when src_valid[s] & src_ready[s]. src_ready[s] = !full[s], computed from registered count only, with no combinational path from dst_ready.
  - Push and pop in the same cycle on a full FIFO is not allowed. Ready is low, so there is no push.
- Head decode:
  - Head of FIFO s requests destination head.tag.
  - If tag >= NUM_DST: pop and drop the head, set err_bad_tag, no output.
- Destination d can load when !dst_valid[d] | dst_ready[d].
- Eligibility:
  - If lock_v[d], only source lock_src[d] is eligible.
  - Otherwise every source whose head requests d is eligible.
- Arbitration:
  - Round-robin starting at rr_ptr[d]+1 mod NUM_SRC.
  - On grant: pop source s, load the output register (valid, sos, eos, data) at the next edge, and set rr_ptr[d] = s.
  - Each source head targets exactly one d, so a source is never double-granted.
- Lock rules (on grant):
  - sos=1, eos=0: lock_v[d]=1, lock_src[d]=s.
  - eos=1: lock_v[d]=0.
  - sos=1, eos=1: single beat, lock unchanged (stays clear).
  - sos=1 while locked: still forwarded, set err_proto.
  - sos=0 while unlocked: forwarded, set err_proto.
- Latency: beat accepted at edge N appears on dst_* after edge N+1 (2 cycles minimum, 1 beat/cycle/destination throughput).
- Stall: while dst_valid[d] & !dst_ready[d], all dst_* for d hold stable and no grant to d occurs.
- conflict_cnt: +1 per cycle for each d that can load and has >=2 eligible requesters (sum over d). Saturates at all 1s.
- Simultaneous events: a grant and a lock release on the same beat are legal. A source may push while its head is popped.

Decomposition:
- sys_defs.svh gets `Num_Banks_FV / `Num_Edge_PE used as the NUM_SRC/NUM_DST defaults.
- Also a packed struct fv_beat_t {sos, eos, tag, data}, shared with the bank controllers.
- Sub-module fv_src_fifo: fv_beat_t, FIFO_DEPTH entries, count-based full/empty, instantiated NUM_SRC times.
- Arbiter is a per-destination generate loop in the top level.

Test Plan:
- Single beat: src0 pushes tag=2, sos=eos=1, data=0xA5 at edge 1 -> dst_valid[2]=1, data 0xA5 after edge 2; other dst_valid stay 0.
- Contention: src0..src3 each push a 1-beat stream to tag 1 in the same cycle, dst_ready=1 -> dst1 outputs src0, src1, src2, src3 on 4 consecutive cycles; conflict_cnt=3.
- Lock: src1 sends a 3-beat stream (sos..eos) to d0 while src2 has a 1-beat stream to d0 queued -> all 3 src1 beats contiguous before src2's beat.
- Backpressure: dst_ready[3]=0 for 5 cycles with src0 streaming to d3 -> dst_* held stable, src_ready[0] drops after FIFO_DEPTH+1 beats are accepted, no loss or reorder on release.
- Errors: tag=7 with NUM_DST=4 (TAG_W=3 override) -> dropped, err_bad_tag=1; a sos=0 beat on an idle destination -> forwarded, err_proto=1.
- Reset mid-stream: assert reset while d0 is locked with 1 beat buffered -> all outputs 0 immediately; after release, a new stream from src3 to d0 is granted with no lock residue.
